// File: rtl/alu_seq_ctrl.sv
// Nibble-serial add/subtract sequencer driving an external combinational 4-bit AU.
// Optional macro ALU_SEQ_OVF_EN adds a registered signed-overflow output (ovf).
module alu_seq_ctrl #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES,
  localparam int IW      = $clog2(NIBBLES)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         c_out,
`ifdef ALU_SEQ_OVF_EN
  output logic         ovf,
`endif
  output logic [3:0]   au_a,
  output logic [3:0]   au_b,
  output logic [1:0]   au_s,
  output logic         au_cin,
  input  logic [3:0]   au_result,
  input  logic         au_cout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [NIBBLES-1:0][3:0] a;
    logic [NIBBLES-1:0][3:0] b;
    logic                    sub;
  } req_t;

  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  state_t                  state;
  req_t                    req;
  logic [IW-1:0]           idx;
  logic                    carry;
  logic [NIBBLES-1:0][3:0] res_q;

  assign result = res_q;

  always_comb begin
    au_a   = '0;
    au_b   = '0;
    au_s   = '0;
    au_cin = 1'b0;
    if (state == RUN) begin
      au_a   = req.a[idx];
      au_b   = req.b[idx];
      au_s   = req.sub ? 2'b10 : 2'b01;
      au_cin = carry;
    end
  end

`ifdef ALU_SEQ_OVF_EN
  // Carry into the MSB is recovered from the MSB sum bit: c3 = a3 ^ b3' ^ s3.
  logic b_msb;
  assign b_msb = req.sub ? ~au_b[3] : au_b[3];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      req   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      res_q <= '0;
      c_out <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          req.a   <= a;
          req.b   <= b;
          req.sub <= op[1];
          idx     <= '0;
          // ADD -> 0, SUB -> 1 (no borrow), ADC/SBB -> caller's carry
          carry   <= op[0] ? c_in : op[1];
          busy    <= 1'b1;
          state   <= RUN;
        end
        RUN: begin
          res_q[idx] <= au_result;
          carry      <= au_cout;
          if (idx == LAST) begin
            c_out <= au_cout;
`ifdef ALU_SEQ_OVF_EN
            ovf   <= au_a[3] ^ b_msb ^ au_result[3] ^ au_cout;
`endif
            idx   <= '0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Nibble-serial sequencer that runs multi-precision add/subtract operations on the existing 4-bit arthmetic_unit. It accepts full-width operands, feeds them to the AU one nibble per clock (least significant first) and chains the carry between nibbles. It collects the result and reports completion. It sits between the register-file/control path and a single external arthmetic_unit instance; the AU stays combinational.

Parameters:
NIBBLES, 4, operand width in nibbles (operand width W = 4*NIBBLES); legal range 2..16.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  request; accepted only in IDLE.
op  in  2  00 ADD, 01 ADC, 10 SUB, 11 SBB.
a  in  W  operand A, sampled on acceptance.
b  in  W  operand B, sampled on acceptance.
c_in  in  1  carry-in for ADC/SBB (SBB: 1 = no borrow).
busy  out  1  high whenever state != IDLE.
done  out  1  one-cycle completion pulse.
result  out  W  final result; held until next acceptance.
c_out  out  1  final carry; for SUB/SBB, 1 = no borrow.
au_a  out  4  nibble of A to AU.
au_b  out  4  nibble of B to AU.
au_s  out  2  AU select: 01 = A+B+Cin, 10 = A+~B+Cin.
au_cin  out  1  AU carry-in.
au_result  in  4  AU result.
au_cout  in  1  AU carry-out.

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE; busy, done, c_out = 0; result = 0; au_* outputs = 0; index, carry and operand registers = 0. The in-flight operation is abandoned and produces no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 at a clock edge (call it E0) does all of the following:
  - latches a, b and op;
  - sets idx=0;
  - loads carry register: 0 for ADD, 1 for SUB, c_in for ADC/SBB;
  - moves to RUN.
  start=0 stays in IDLE.
- RUN, combinational drive:
  - au_a = a_reg[4*idx+:4], au_b = b_reg[4*idx+:4];
  - au_cin = carry register;
  - au_s = 01 for ADD/ADC, 10 for SUB/SBB.
- RUN, each edge:
  - result[4*idx+:4] <= au_result;
  - carry register <= au_cout;
  - idx increments.
  - On the edge that captures nibble NIBBLES-1, c_out <= au_cout and state moves to DONE.
- DONE: done=1 for exactly one cycle, then IDLE on the next edge.
  - Latency: done is high in the cycle following edge E(NIBBLES), i.e. NIBBLES cycles after acceptance.
- busy is high in RUN and DONE. start is ignored (not queued) in RUN and DONE. Inputs a/b/op/c_in may change freely after E0.
- result is updated nibble-by-nibble during RUN. It is only guaranteed valid while done=1 and thereafter until the next acceptance.
- Outside RUN, au_a, au_b, au_s and au_cin are 0.
- Arithmetic is modulo 2^W; the final carry is reported only on c_out. Wrap-around (e.g. FFFF+1) gives result 0 with c_out=1.
- idx is ceil(log2(NIBBLES)) bits wide and never exceeds NIBBLES-1.

Optional Feature:
ALU_SEQ_OVF_EN: when defined, adds output port ovf (1 bit).
- ovf is computed at the final nibble as carry-into-MSB XOR carry-out-of-MSB, i.e. two's-complement signed overflow.
- It is registered alongside c_out, cleared by reset and held like result.
When the macro is undefined, the ovf port and its logic do not exist. All other behaviour is identical in both builds.

Test Plan:
1. NIBBLES=4, ADD, a=0x1234, b=0x0FFF, start for 1 cycle -> busy during 5 cycles; done pulse 4 cycles after acceptance; result=0x2233, c_out=0.
2. ADD, a=0xFFFF, b=0x0001 -> result=0x0000, c_out=1 (wrap-around, carry ripples through all 4 nibbles).
3. SUB, a=0x0005, b=0x0007 -> result=0xFFFE, c_out=0 (borrow). SUB, a=0x0007, b=0x0005 -> result=0x0002, c_out=1.
4. ADC, a=0x00FF, b=0x0000, c_in=1 -> 0x0100, c_out=0. SBB, a=0x0010, b=0x0001, c_in=0 -> 0x000E, c_out=1.
5. start held high through an operation, with a/b changed at cycle 2 -> exactly one done pulse with the original-operand result; second operation accepted only after return to IDLE. Assert rst in the 2nd RUN cycle -> all outputs 0 immediately, no done pulse, next start works normally.
6. With ALU_SEQ_OVF_EN defined: ADD 0x7FFF+0x0001 -> result=0x8000, ovf=1, c_out=0; SUB 0x8000-0x0001 -> 0x7FFF, ovf=1; ADD 0x0001+0x0001 -> ovf=0.
